// File: rtl/final_fpga_cpu_mult_seq.sv
// -----------------------------------------------------------------------------
// final_fpga_cpu_mult_seq
//
// Iterative multiplier that sits beside the CPU ALU in the M stage. The full
// 2*DATA_W product of src1 x src2 is built from DATA_W x LANE_W partial
// products, one LANE_W slice of the multiplier per cycle. Signed modes are
// handled by multiplying magnitudes and applying the sign in a final FIX cycle.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   start    in   operation request, accepted only while idle
//   kill     in   abort the operation in flight (pipeline flush)
//   mode     in   00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU (high word)
//   src1     in   multiplicand, sampled on accept
//   src2     in   multiplier, sampled on accept
//   busy     out  high from the accept edge until the done edge
//   done     out  one-cycle pulse, result valid
//   result   out  selected product word, held until the next done
// -----------------------------------------------------------------------------
module final_fpga_cpu_mult_seq #(
  parameter int DATA_W = 32,  // must be an integer multiple of LANE_W
  parameter int LANE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              kill,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int N_LANES = DATA_W / LANE_W;
  localparam int ACC_W   = 2 * DATA_W;
  localparam int PP_W    = DATA_W + LANE_W;
  localparam int CNT_W   = $clog2(N_LANES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude of a signed operand. The most negative value
  // maps onto itself, which is exactly its magnitude when read as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    if (is_signed && v[DATA_W-1]) begin
      return ~v + DATA_W'(1);
    end
    return v;
  endfunction

  // Apply the product sign over the full double-width accumulator.
  function automatic logic [ACC_W-1:0] apply_sign(input logic [ACC_W-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + ACC_W'(1)) : v;
  endfunction

  state_t             state_q,  state_d;
  logic [ACC_W-1:0]   acc_q,    acc_d;
  logic [DATA_W-1:0]  mag1_q,   mag1_d;
  logic [DATA_W-1:0]  mag2_q,   mag2_d;
  logic [CNT_W-1:0]   lane_q,   lane_d;
  logic               neg_q,    neg_d;
  logic [1:0]         mode_q,   mode_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q,   done_d;

  logic               signed1;
  logic               signed2;
  logic [PP_W-1:0]    pp;
  logic [ACC_W-1:0]   pp_shifted;
  logic [ACC_W-1:0]   prod;
  logic               last_lane;

  // MULXSU treats only src1 as signed; MUL is sign-invariant in the low word.
  assign signed1 = mode[1];
  assign signed2 = (mode == 2'b10);

  // mag2_q is shifted down each MUL cycle, so its bottom slice is always the
  // current lane; the partial product is realigned by the lane index.
  assign pp         = {{LANE_W{1'b0}}, mag1_q} * {{DATA_W{1'b0}}, mag2_q[LANE_W-1:0]};
  assign pp_shifted = ACC_W'(pp) << (LANE_W * int'(lane_q));
  assign prod       = apply_sign(acc_q, neg_q);
  assign last_lane  = (lane_q == CNT_W'(N_LANES - 1));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mag1_d   = mag1_q;
    mag2_d   = mag2_q;
    lane_d   = lane_q;
    neg_d    = neg_q;
    mode_d   = mode_q;
    result_d = result_q;
    done_d   = 1'b0;

    // kill wins over everything in flight, including FIX completion.
    if (kill && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !kill) begin
            mag1_d  = magnitude(src1, signed1);
            mag2_d  = magnitude(src2, signed2);
            neg_d   = (signed1 & src1[DATA_W-1]) ^ (signed2 & src2[DATA_W-1]);
            mode_d  = mode;
            acc_d   = '0;
            lane_d  = '0;
            state_d = S_MUL;
          end
        end
        S_MUL: begin
          acc_d  = acc_q + pp_shifted;
          mag2_d = mag2_q >> LANE_W;
          lane_d = lane_q + CNT_W'(1);
          if (last_lane) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = (mode_q == 2'b00) ? prod[DATA_W-1:0] : prod[ACC_W-1:DATA_W];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mag1_q   <= '0;
      mag2_q   <= '0;
      lane_q   <= '0;
      neg_q    <= 1'b0;
      mode_q   <= 2'b00;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mag1_q   <= mag1_d;
      mag2_q   <= mag2_d;
      lane_q   <= lane_d;
      neg_q    <= neg_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // busy drops on the same edge that raises done.
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_final_fpga_cpu_mult_seq.sv
// -----------------------------------------------------------------------------
// Testbench for final_fpga_cpu_mult_seq: a 32-bit and a 64-bit instance
// (LANE_W=16) checked against a double-width sign-extension reference model.
// -----------------------------------------------------------------------------
module tb_final_fpga_cpu_mult_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, kill;
  logic [1:0]  mode;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  logic        start64, kill64;
  logic [1:0]  mode64;
  logic [63:0] a64, b64;
  logic        busy64, done64;
  logic [63:0] res64;

  final_fpga_cpu_mult_seq #(.DATA_W(32), .LANE_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .mode(mode),
    .src1(src1), .src2(src2), .busy(busy), .done(done), .result(result)
  );

  final_fpga_cpu_mult_seq #(.DATA_W(64), .LANE_W(16)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .start(start64), .kill(kill64), .mode(mode64),
    .src1(a64), .src2(b64), .busy(busy64), .done(done64), .result(res64)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q32[$];
  logic [63:0] q64[$];

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sign- or zero-extend both operands to 128 bits and multiply.
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] m,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] mask, ea, eb, p;
    logic s1, s2;
    mask = (128'(1) << w) - 128'(1);
    s1 = (m == 2'b10) || (m == 2'b11);
    s2 = (m == 2'b10);
    ea = 128'(a) & mask;
    eb = 128'(b) & mask;
    if (s1 && a[w-1]) ea = ea | ~mask;
    if (s2 && b[w-1]) eb = eb | ~mask;
    p = ea * eb;
    if (m == 2'b00) return 64'(p & mask);
    return 64'((p >> w) & mask);
  endfunction

  // One 32-bit operation, called on a negedge with the DUT idle.
  task automatic run32(input string name, input logic [1:0] m,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int lat;
    logic [31:0] e;
    mode = m; src1 = a; src2 = b; start = 1'b1;
    q32.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); src1 = $urandom; src2 = $urandom;
    check({name, "_busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd4);
    e = q32.pop_front();
    if (done) check({name, "_result"}, 64'(result), 64'(e));
  endtask

  task automatic run64(input string name, input logic [1:0] m,
                       input logic [63:0] a, input logic [63:0] b);
    int lat;
    logic [63:0] e;
    mode64 = m; a64 = a; b64 = b; start64 = 1'b1;
    q64.push_back(ref_mul(64, m, a, b));
    @(negedge clk);
    start64 = 1'b0;
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    lat = 1;
    while (!done64 && lat < 14) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd6);
    e = q64.pop_front();
    if (done64) check({name, "_result"}, res64, e);
  endtask

  initial begin
    int seen;
    logic [31:0] e;
    logic [1:0]  m;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[8]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[10] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[11] = '{2'b11, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[12] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};

    reset_n = 1'b0; start = 1'b0; kill = 1'b0; mode = 2'b00; src1 = '0; src2 = '0;
    start64 = 1'b0; kill64 = 1'b0; mode64 = 2'b00; a64 = '0; b64 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result64", res64, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run32($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Reset one cycle after accept: nothing may complete, result clears.
    mode = 2'b00; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("rstmid_no_done", 64'(seen), 64'd0);

    // start together with kill while idle is ignored.
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("idle_kill_start_busy", 64'(busy), 64'd0);

    run32("pre_kill", 2'b00, 32'd3, 32'd5, 32'd15);

    // Kill during MUL.
    mode = 2'b00; src1 = 32'd100; src2 = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("killmul_busy", 64'(busy), 64'd0);
    check("killmul_done", 64'(done), 64'd0);
    check("killmul_result", 64'(result), 64'd15);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("killmul_no_done", 64'(seen), 64'd0);

    // Kill in the FIX cycle, then a new start on the very next edge.
    mode = 2'b00; src1 = 32'd9; src2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("killfix_pre_busy", 64'(busy), 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("killfix_done", 64'(done), 64'd0);
    check("killfix_busy", 64'(busy), 64'd0);
    check("killfix_result", 64'(result), 64'd15);
    run32("after_killfix", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1);

    // start held high with new operands every cycle: one accept per 4 cycles.
    for (int c = 0; c < 16; c++) begin
      mode = 2'($urandom); src1 = $urandom; src2 = $urandom; start = 1'b1;
      if ((c % 4) == 0) q32.push_back(32'(ref_mul(32, mode, 64'(src1), 64'(src2))));
      @(negedge clk);
      check($sformatf("b2b_done_c%0d", c), 64'(done), 64'((c % 4) == 3));
      if (done && (q32.size() > 0)) begin
        e = q32.pop_front();
        check($sformatf("b2b_result_c%0d", c), 64'(result), 64'(e));
      end
    end
    start = 1'b0;
    check("b2b_all_done", 64'(q32.size()), 64'd0);
    q32.delete();
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      m  = 2'($urandom);
      ra = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
      rb = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      run32($sformatf("rnd32_%0d", i), m, ra, rb, 32'(ref_mul(32, m, 64'(ra), 64'(rb))));
    end

    run64("w64_min", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run64("w64_ones", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 16; i++) begin
      run64($sformatf("rnd64_%0d", i), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/final_fpga_cpu_mult_seq.md
Name: final_fpga_cpu_mult_seq

Overview:
- Parametrised, iterative successor to the CPU's fixed 32x32 low-word multiply cell.
- Computes the full 2*DATA_W product of src1 x src2 from LANE_W-wide partial products, one lane per cycle, with start/done handshake.
- Returns the low word (MUL) or high word (MULXUU / MULXSS / MULXSU) of the product.
- Sits beside the CPU ALU in the M stage; the CPU stalls on busy and captures result on done.

Parameters:
- DATA_W, 32, operand/result width; must be an integer multiple of LANE_W.
- LANE_W, 16, width of src2 slice multiplied per cycle (maps to one hard multiplier of DATA_W x LANE_W).
- N_LANES, DATA_W/LANE_W, derived (localparam); number of MUL iterations.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- kill  in  1  abort current operation (pipeline flush).
- mode  in  2  00 MUL low word; 01 MULXUU high; 10 MULXSS high; 11 MULXSU high (src1 signed, src2 unsigned).
- src1  in  DATA_W  multiplicand, sampled on accept.
- src2  in  DATA_W  multiplier, sampled on accept.
- busy  out  1  high from accept edge until done edge inclusive.
- done  out  1  one-cycle pulse, result valid.
- result  out  DATA_W  selected product word; held until next done.

Behaviour:
- Reset (async, reset_n=0): state IDLE, busy=0, done=0, result=0, accumulator/lane counter=0. Reset mid-operation discards everything; no done.
- States: IDLE, MUL, FIX.
- IDLE: start=1 & kill=0 at edge -> latch |src1|, |src2| per mode signedness, neg_flag = sign1 XOR sign2 (signed operands only), latch mode, acc=0, lane=0, busy=1, -> MUL. start with kill=1 in IDLE: ignored.
- Magnitudes: signed operand with MSB=1 is negated to a DATA_W-bit unsigned value (most-negative 0x80000000 -> 0x80000000 unsigned, exact). Mode 00 treats both unsigned (low word is sign-invariant).
- MUL: each edge acc += mag1 * mag2[lane*LANE_W +: LANE_W] << (lane*LANE_W); acc is 2*DATA_W bits, no overflow possible. lane increments; after lane N_LANES-1 -> FIX.
- FIX: p = neg_flag ? -acc : acc (2*DATA_W two's complement); result <= mode==00 ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W]; done=1 for that one cycle; busy=0 after that edge; -> IDLE.
- Latency: accept at edge t; done high from edge t+N_LANES+1 for exactly one cycle (DATA_W=32, LANE_W=16: 3 edges). Throughput: new start may be accepted on the edge after done (done cycle is IDLE-bound; start sampled in done cycle is accepted if state already IDLE, i.e. back-to-back every N_LANES+2 cycles).
- start while busy: ignored, no queueing; operands not re-sampled.
- kill while busy (MUL or FIX): -> IDLE next edge, busy=0, no done, result unchanged. kill takes priority over FIX completion.
- Operand/mode inputs may change freely after accept.
- result holds last completed value; never glitches on kill/start.

Test Plan:
- Reset mid-MUL: assert reset_n=0 one cycle after accept -> busy=0, done never pulses, result=0.
- mode=00, src1=0x00000007, src2=0xFFFFFFFD -> done 3 edges after accept, result=0xFFFFFFEB; mode=10 same operands -> result=0xFFFFFFFF.
- src1=src2=0xFFFFFFFF: mode 00 -> 0x00000001; 01 -> 0xFFFFFFFE; 10 -> 0x00000000; 11 -> 0xFFFFFFFF.
- mode=10, src1=src2=0x80000000 -> result=0x40000000; mode=00 -> 0x00000000; mode=01, src1=src2=0x00010000 -> 0x00000001.
- Handshake: start held high continuously with varying operands -> one done every 4 cycles, each result matching operands at its accept edge; start during busy not accepted.
- kill asserted in FIX cycle -> no done, result retains previous value, next start accepted next edge; random sweep (DATA_W=32 and 64, LANE_W=16) vs 2*DATA_W reference model all modes.
